mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Shares one 32x32->64 unsigned pipelined multiplier (fixed latency, one issue per cycle, no stall input) between N_REQ requesters. Arbitrates per cycle with round-robin priority, drives the operands into the multiplier, and carries a tag pipeline alongside the multiplier stages so each result returns to the requester that issued it. Sits between the functional-unit clients and the multiplier instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- LATENCY, 2, multiplier latency in clock edges from operand capture to valid result (>=1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operation request
- req_a  in  32*N_REQ  operand A; requester i uses bits [32*i+31:32*i]
- req_b  in  32*N_REQ  operand B, same packing
- req_ready  out  N_REQ  one-hot grant; accept when req_valid[i] & req_ready[i]
- rsp_valid  out  N_REQ  one-hot result strobe to the issuing requester
- rsp_r  out  64  result, shared by all requesters, qualified by rsp_valid
- mul_a  out  32  operand A to multiplier
- mul_b  out  32  operand B to multiplier
- mul_r  in  64  multiplier result
- issue_count  out  32  total accepted operations, wraps modulo 2^32

## Operation
- Grant: among set req_valid bits, choose the first at or after rr_ptr (ascending index, wrapping). req_ready is one-hot for that index, or all-zero if no req_valid bit is set. req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Accept: on each rising edge with any req_valid set, exactly one operation issues. rr_ptr <= (granted index + 1) mod N_REQ. rr_ptr is unchanged when idle.
- Operand mux: mul_a/mul_b = granted requester's operands. When idle, mul_a/mul_b = 0.
- Tag pipeline: LATENCY stages of {valid, index}. Stage 0 captures {1, granted index} on accept, or {0, x} when idle. Each stage shifts every cycle, with no stall.
- Response: rsp_valid = one-hot(last-stage index) when the last-stage valid is 1, else 0. rsp_r = mul_r, passed through combinationally and not registered. Responses cannot be refused; a requester must consume rsp_valid in the cycle it is high.
- A requester may have up to LATENCY operations in flight. Results return in issue order.
- issue_count increments by 1 on every accept and wraps from 0xFFFFFFFF to 0.

## Timing
- Accept in cycle T (handshake at edge E_T) -> rsp_valid high during cycle T+LATENCY, with the product on rsp_r in that same cycle.
- Throughput: one operation per cycle, sustained.
- Reset values:
  - rsp_valid = 0.
  - All tag stages are invalid.
  - rr_ptr = 0.
  - issue_count = 0.
  - req_ready is driven combinationally, so with rr_ptr = 0 it reflects the lowest-index valid requester as soon as reset asserts.
- Reset mid-operation: every in-flight tag is discarded immediately (asynchronously), and no rsp_valid pulse appears for those operations. Garbage on mul_r is ignored.
- Simultaneous response and new accept by the same requester in one cycle is legal and independent.
- First accept after reset deasserts: grant starts from index 0.

## Configuration
- MULT_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest set index always wins and rr_ptr is not implemented. A continuously requesting requester 0 starves the others.
- MULT_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single op, defaults: requester 2 requests a=0xFFFFFFFF, b=0xFFFFFFFF at cycle 5 with the others idle.
  - req_ready = 4'b0100.
  - rsp_valid = 4'b0100 at cycle 7 with rsp_r = 0xFFFFFFFE00000001.
  - issue_count = 1.
- Round-robin: all four requesters hold req_valid for 8 cycles, with requester i using a=i+1, b=3.
  - Grants go 0,1,2,3,0,1,2,3.
  - Responses arrive two cycles later in the same order, with rsp_r = 3,6,9,12,3,6,9,12.
- Back-to-back same requester: requester 1 streams a=k, b=k for k=1..6, others idle.
  - req_ready is high for 6 consecutive cycles.
  - rsp_r = 1,4,9,16,25,36 on consecutive cycles; no bubbles.
- Reset mid-flight: issue 2 ops, then assert rst_n low for 1 cycle one cycle after the second accept.
  - No rsp_valid pulses follow.
  - issue_count = 0.
  - The next request from requester 3 alone is granted and returns correctly.
- Fixed priority build (MULT_ARB_FIXED_PRIO_EN defined): requesters 0 and 2 both hold req_valid for 4 cycles.
  - Requester 0 is granted all 4 cycles.
  - Requester 2 is granted only once requester 0 drops req_valid.
- Counter wrap: force 0xFFFFFFFE accepts (or preload in sim), then 2 more accepts.
  - issue_count reads 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined 32x32->64 multiplier among N_REQ requesters with a tag pipeline that
// routes each result back to its issuer. Define MULT_ARB_FIXED_PRIO_EN for fixed priority.
module mult_share_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [32*N_REQ-1:0]     req_a,
   input  logic [32*N_REQ-1:0]     req_b,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [63:0]             rsp_r,
   output logic [31:0]             mul_a,
   output logic [31:0]             mul_b,
   input  logic [63:0]             mul_r,
   output logic [31:0]             issue_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic             gnt_any;
   logic [IDX_W-1:0] gnt_idx;
   logic [CNT_W-1:0] issue_count_q, issue_count_d;
   logic [LATENCY-1:0] tag_vld_q;
   logic [IDX_W-1:0]   tag_idx_q [LATENCY];

`ifdef MULT_ARB_FIXED_PRIO_EN
   // Lowest set index always wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_idx = IDX_W'(cand);
         if (!gnt_any && req_valid[cand_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) begin
         rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`endif

   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (gnt_any) begin
         req_ready = N_REQ'(1) << gnt_idx;
         mul_a     = req_a[DATA_W*gnt_idx +: DATA_W];
         mul_b     = req_b[DATA_W*gnt_idx +: DATA_W];
      end
   end

   always_comb begin
      issue_count_d = issue_count_q;
      if (gnt_any) issue_count_d = issue_count_q + CNT_W'(1);
   end

   // Tag pipeline runs in lockstep with the multiplier stages; reset drops in-flight tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_count_q <= '0;
         tag_vld_q     <= '0;
         for (int unsigned s = 0; s < LATENCY; s++) tag_idx_q[s] <= '0;
      end else begin
         issue_count_q <= issue_count_d;
         tag_vld_q[0]  <= gnt_any;
         tag_idx_q[0]  <= gnt_idx;
         for (int unsigned s = 1; s < LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (tag_vld_q[LATENCY-1]) rsp_valid = N_REQ'(1) << tag_idx_q[LATENCY-1];
   end

   assign rsp_r       = mul_r;
   assign issue_count = issue_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed steps plus random traffic against a queue-based model.
module tb_mult_share_arbiter;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [32*N-1:0]  req_a;
   logic [32*N-1:0]  req_b;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     rsp_valid;
   logic [63:0]      rsp_r;
   logic [31:0]      mul_a;
   logic [31:0]      mul_b;
   logic [63:0]      mul_r;
   logic [31:0]      issue_count;

   mult_share_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_r(rsp_r),
      .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   // Two-stage multiplier model feeding mul_r.
   logic [63:0] p1, p2;
   always @(posedge clk) begin
      p1 <= 64'(mul_a) * 64'(mul_b);
      p2 <= p1;
   end
   assign mul_r = p2;

   typedef struct {
      int          idx;
      logic [63:0] prod;
      int          due;
   } rsp_t;

   rsp_t        exp_q[$];
   int          ptr;
   int          cyc;
   logic [31:0] cnt;
   int          n_vec;
   int          n_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v);
      int start;
`ifdef MULT_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = ptr;
`endif
      for (int k = 0; k < N; k++) begin
         if (v[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   // One cycle: apply inputs at negedge, check against model, advance model at posedge.
   task automatic step(input logic [N-1:0] v, input logic [32*N-1:0] a, input logic [32*N-1:0] b);
      int          g;
      logic [N-1:0] er;
      logic [31:0] ea, eb;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      #1;
      g  = model_grant(v);
      er = (g >= 0) ? N'(1) << g : '0;
      ea = (g >= 0) ? a[32*g +: 32] : 32'h0;
      eb = (g >= 0) ? b[32*g +: 32] : 32'h0;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("mul_a", 64'(mul_a), 64'(ea));
      chk("mul_b", 64'(mul_b), 64'(eb));
      chk("issue_count", 64'(issue_count), 64'(cnt));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << exp_q[0].idx));
         chk("rsp_r", rsp_r, exp_q[0].prod);
         void'(exp_q.pop_front());
      end else begin
         chk("rsp_valid_idle", 64'(rsp_valid), 64'h0);
      end
      @(posedge clk);
      if (g >= 0) begin
         ptr = (g + 1) % N;
         cnt = cnt + 32'd1;
         exp_q.push_back('{idx: g, prod: 64'(ea) * 64'(eb), due: cyc + LAT});
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, '0);
   endtask

   logic [32*N-1:0] va, vb;
   logic [N-1:0]    vv;

   initial begin
      clk = 1'b0; rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      ptr = 0; cyc = 0; cnt = 32'd0; n_vec = 0; n_err = 0;
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("reset_issue_count", 64'(issue_count), 64'h0);
      chk("reset_ready_idle", 64'(req_ready), 64'h0);
      req_valid = 4'b0110;
      #1;
      chk("reset_ready_comb", 64'(req_ready), 64'h2);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single op from requester 2 with max operands.
      idle(4);
      va = '0; vb = '0;
      va[64 +: 32] = 32'hFFFF_FFFF; vb[64 +: 32] = 32'hFFFF_FFFF;
      step(4'b0100, va, vb);
      idle(3);
      chk("single_count", 64'(issue_count), 64'h1);

      // All four requesters hold valid for 8 cycles.
      va = '0; vb = '0;
      for (int i = 0; i < N; i++) begin
         va[32*i +: 32] = 32'(i + 1);
         vb[32*i +: 32] = 32'd3;
      end
      for (int i = 0; i < 8; i++) step(4'b1111, va, vb);
      idle(3);

      // Requester 1 streams back-to-back.
      for (int k = 1; k <= 6; k++) begin
         va = '0; vb = '0;
         va[32 +: 32] = 32'(k); vb[32 +: 32] = 32'(k);
         step(4'b0010, va, vb);
      end
      idle(3);

      // Reset one cycle after the second accept; in-flight ops are dropped.
      va = '0; vb = '0;
      va[0 +: 32] = 32'd7;  vb[0 +: 32] = 32'd9;
      step(4'b0001, va, vb);
      va[0 +: 32] = 32'd11; vb[0 +: 32] = 32'd13;
      step(4'b0001, va, vb);
      rst_n = 1'b0;
      exp_q.delete(); ptr = 0; cnt = 32'd0;
      #1;
      chk("midreset_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("midreset_count", 64'(issue_count), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc++;
      idle(3);
      va = '0; vb = '0;
      va[96 +: 32] = 32'h1234_5678; vb[96 +: 32] = 32'h9ABC_DEF0;
      step(4'b1000, va, vb);
      idle(3);

`ifdef MULT_ARB_FIXED_PRIO_EN
      // Requester 0 keeps winning over requester 2.
      va = '0; vb = '0;
      va[0 +: 32] = 32'd5; vb[0 +: 32] = 32'd6; va[64 +: 32] = 32'd8; vb[64 +: 32] = 32'd9;
      for (int i = 0; i < 4; i++) step(4'b0101, va, vb);
      step(4'b0100, va, vb);
      idle(3);
`endif

      // Counter wrap via preload.
      force dut.issue_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.issue_count_q;
      cnt = 32'hFFFF_FFFE;
      va = '0; vb = '0;
      va[32 +: 32] = 32'd2; vb[32 +: 32] = 32'd3;
      step(4'b0010, va, vb);
      chk("wrap_ffffffff", 64'(issue_count), 64'hFFFF_FFFF);
      step(4'b0010, va, vb);
      chk("wrap_zero", 64'(issue_count), 64'h0);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         vv = (($urandom & 3) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
         for (int r = 0; r < N; r++) begin
            va[32*r +: 32] = $urandom;
            vb[32*r +: 32] = (($urandom & 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         end
         step(vv, va, vb);
      end
      idle(4);
      chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
